dartboard_turn_sequencer: RTL and testbench
===========================================

DARTBOARD_TURN_SEQUENCER -- requirements
Module: dartboard_turn_sequencer

Interface
REQ-001 Parameter: START_SCORE, default 501, initial score of each player (range 2..511).
REQ-002 Parameter: DOUBLE_OUT, default 1, 1 = finishing dart SHALL be a double (bull counts as double when multiplier=2).
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset; asserting it (low) forces the reset state immediately, release is synchronous to clk.
REQ-005 Port: new_game  input  1  synchronous pulse; restarts the game from any state.
REQ-006 Port: throw_valid  input  1  dart result present this cycle.
REQ-007 Port: throw_ready  output  1  sequencer can accept a dart this cycle.
REQ-008 Port: points  input  5  segment value; legal 0..20 or 25 (bull).
REQ-009 Port: multiplier  input  3  legal 1..3; bull legal only with 1 or 2.
REQ-010 Port: undo  input  1  synchronous pulse; retract last dart of the current turn.
REQ-011 Port: score_p0, score_p1  output  9 each  remaining score per player.
REQ-012 Port: active_player  output  1  player whose turn it is.
REQ-013 Port: darts_left  output  2  darts remaining in current turn (3..0).
REQ-014 Port: bust, illegal_throw  output  1 each  single-cycle status pulses.
REQ-015 Port: game_over  output  1  level, high once a player has finished.
REQ-016 Port: winner  output  1  valid while game_over=1.

Function
REQ-017 States SHALL be THROW, TURN_END, GAME_OVER; reset and new_game enter THROW.
REQ-018 A dart is accepted in a cycle where throw_valid=1 and throw_ready=1; throw_ready = (state==THROW) and not undo and not new_game.
REQ-019 Dart value = points x multiplier, computed 6 bits wide (max 60); illegal points/multiplier SHALL be scored as 0 points, still consume a dart, and pulse illegal_throw the following cycle.
REQ-020 Score subtraction SHALL be done 10 bits signed: rem = score[active] - value.
REQ-021 Bust when rem<0, or DOUBLE_OUT=1 and rem==1, or DOUBLE_OUT=1 and rem==0 with multiplier!=2; on bust the active score SHALL be restored to its turn-start value, bust pulses, next state TURN_END.
REQ-022 Finish when rem==0 and not bust: score written 0, winner=active_player, game_over=1, next state GAME_OVER.
REQ-023 Otherwise score[active] <= rem, darts_left decrements; when darts_left reaches 0 next state is TURN_END, else remain THROW.
REQ-024 All score/status outputs SHALL update on the clock edge that accepts the dart (visible the cycle after acceptance); bust/illegal_throw high for exactly that one cycle.
REQ-025 TURN_END SHALL last exactly one cycle with throw_ready=0, then toggle active_player, set darts_left=3, latch the new player's score as turn-start value, return to THROW.
REQ-026 The sequencer SHALL store up to 3 accepted dart values of the current turn; undo in THROW with darts_left<3 SHALL add back the last stored value, increment darts_left, and pop it.
REQ-027 undo with darts_left==3, in TURN_END, or in GAME_OVER SHALL have no effect; undo never crosses a turn boundary.
REQ-028 undo and throw_valid in the same cycle: undo is performed, the throw is not accepted (throw_ready=0).
REQ-029 GAME_OVER holds all scores, throw_ready=0, until new_game or reset.
REQ-030 new_game has priority over undo and throws; it takes effect on the next edge with the same values as reset.

Reset
REQ-031 Reset (and new_game) SHALL set score_p0=score_p1=START_SCORE, active_player=0, darts_left=3, bust=0, illegal_throw=0, game_over=0, winner=0, undo stack empty, state THROW.
REQ-032 Reset asserted mid-turn or in TURN_END SHALL discard all turn state with no partial update.

Verification
REQ-033 Normal turn: P0 throws 20x3, 20x3, 20x3 -> score_p0=321, TURN_END one cycle, active_player=1, darts_left=3.
REQ-034 Bust: P0 at 40 throws 20x1 then 19x1 (rem 1) -> bust pulse, score_p0=40, turn passes to P1.
REQ-035 Checkout: P1 at 40 throws 20x2 -> score_p1=0, game_over=1, winner=1, throw_ready=0; 20x1 at 20 with DOUBLE_OUT=1 -> bust instead.
REQ-036 Undo: P0 at 501 throws 25x2 (451), undo -> 501, darts_left=3; second undo -> no change; undo+throw_valid same cycle -> throw ignored.
REQ-037 Illegal: points=22 multiplier=1, then points=25 multiplier=3 -> illegal_throw pulse each, score unchanged, darts_left decrements by 1 each.
REQ-038 Async reset asserted mid-clock during turn with score_p0=321 -> outputs at reset values without waiting for a clock edge; new_game in GAME_OVER -> same values one cycle later.

Source files
------------

// File: rtl/dartboard_turn_sequencer.sv
// dartboard_turn_sequencer
//   Turn and score sequencer for a two-player x01 darts game. Each player
//   gets three darts per turn. A dart is scored as points x multiplier and
//   subtracted from the active player's score. If the dart overshoots, or
//   cannot be finished on a double when DOUBLE_OUT is set, the player busts:
//   the score returns to its turn-start value and the turn passes to the
//   other player. Reaching exactly zero finishes the game. The last darts of
//   the current turn can be retracted with undo.
//
// Parameters
//   START_SCORE    initial score of each player (2..511)
//   DOUBLE_OUT     1 = the finishing dart must have multiplier 2
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   new_game       synchronous restart; takes priority over everything else
//   throw_valid    dart result present this cycle
//   throw_ready    a dart can be accepted this cycle
//   points         segment value (0..20 legal, 25 = bull)
//   multiplier     1..3 legal (bull only with 1 or 2)
//   undo           retract the last dart of the current turn
//   score_p0/p1    remaining score per player
//   active_player  player whose turn it is
//   darts_left     darts remaining in the current turn
//   bust           one-cycle pulse after a busting dart
//   illegal_throw  one-cycle pulse after an illegal dart
//   game_over      level, high once a player has finished
//   winner         finishing player, valid while game_over is high
module dartboard_turn_sequencer #(
  parameter int unsigned START_SCORE = 501,
  parameter bit          DOUBLE_OUT  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       throw_valid,
  output logic       throw_ready,
  input  logic [4:0] points,
  input  logic [2:0] multiplier,
  input  logic       undo,
  output logic [8:0] score_p0,
  output logic [8:0] score_p1,
  output logic       active_player,
  output logic [1:0] darts_left,
  output logic       bust,
  output logic       illegal_throw,
  output logic       game_over,
  output logic       winner
);

  localparam logic [8:0] START = START_SCORE[8:0];

  typedef enum logic [1:0] {
    S_THROW     = 2'd0,
    S_TURN_END  = 2'd1,
    S_GAME_OVER = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0][8:0]  score_q, score_d;
  logic [8:0]       turn_start_q, turn_start_d;
  logic             active_q, active_d;
  logic [1:0]       darts_left_q, darts_left_d;
  logic [2:0][5:0]  stack_q, stack_d;
  logic             bust_q, bust_d;
  logic             illegal_q, illegal_d;
  logic             game_over_q, game_over_d;
  logic             winner_q, winner_d;

  logic             legal;
  logic [5:0]       value;
  logic [8:0]       cur_score;
  logic signed [9:0] rem;
  logic             is_bust;
  logic [1:0]       push_idx;
  logic [1:0]       pop_idx;

  // Dart classification and the tentative remaining score.
  always_comb begin
    legal = (multiplier >= 3'd1) && (multiplier <= 3'd3) &&
            ((points <= 5'd20) || ((points == 5'd25) && (multiplier <= 3'd2)));
    value = legal ? (6'(points) * 6'(multiplier)) : '0;
    cur_score = score_q[active_q];
    rem = $signed({1'b0, cur_score}) - $signed({4'b0000, value});
    is_bust = (rem < 0) ||
              (DOUBLE_OUT && (rem == 10'sd1)) ||
              (DOUBLE_OUT && (rem == 10'sd0) && (multiplier != 3'd2));
  end

  // The undo stack depth equals darts already thrown (3 - darts_left), so the
  // push slot and the top-of-stack slot are derived from darts_left.
  assign push_idx = 2'd3 - darts_left_q;
  assign pop_idx  = 2'd2 - darts_left_q;

  assign throw_ready = (state_q == S_THROW) && !undo && !new_game;

  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    turn_start_d = turn_start_q;
    active_d     = active_q;
    darts_left_d = darts_left_q;
    stack_d      = stack_q;
    bust_d       = 1'b0;
    illegal_d    = 1'b0;
    game_over_d  = game_over_q;
    winner_d     = winner_q;

    if (new_game) begin
      state_d      = S_THROW;
      score_d      = {START, START};
      turn_start_d = START;
      active_d     = 1'b0;
      darts_left_d = 2'd3;
      stack_d      = '0;
      game_over_d  = 1'b0;
      winner_d     = 1'b0;
    end else begin
      case (state_q)
        S_THROW: begin
          if (undo) begin
            if (darts_left_q != 2'd3) begin
              score_d[active_q] = cur_score + 9'(stack_q[pop_idx]);
              darts_left_d      = darts_left_q + 2'd1;
            end
          end else if (throw_valid) begin
            illegal_d         = !legal;
            stack_d[push_idx] = value;
            if (is_bust) begin
              score_d[active_q] = turn_start_q;
              bust_d            = 1'b1;
              state_d           = S_TURN_END;
            end else if (rem == 10'sd0) begin
              score_d[active_q] = '0;
              game_over_d       = 1'b1;
              winner_d          = active_q;
              state_d           = S_GAME_OVER;
            end else begin
              score_d[active_q] = rem[8:0];
              darts_left_d      = darts_left_q - 2'd1;
              if (darts_left_q == 2'd1) begin
                state_d = S_TURN_END;
              end
            end
          end
        end
        S_TURN_END: begin
          active_d     = ~active_q;
          darts_left_d = 2'd3;
          turn_start_d = score_q[~active_q];
          state_d      = S_THROW;
        end
        S_GAME_OVER: begin
          state_d = S_GAME_OVER;
        end
        default: begin
          state_d = S_THROW;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_THROW;
      score_q      <= {START, START};
      turn_start_q <= START;
      active_q     <= 1'b0;
      darts_left_q <= 2'd3;
      stack_q      <= '0;
      bust_q       <= 1'b0;
      illegal_q    <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      turn_start_q <= turn_start_d;
      active_q     <= active_d;
      darts_left_q <= darts_left_d;
      stack_q      <= stack_d;
      bust_q       <= bust_d;
      illegal_q    <= illegal_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
    end
  end

  assign score_p0      = score_q[0];
  assign score_p1      = score_q[1];
  assign active_player = active_q;
  assign darts_left    = darts_left_q;
  assign bust          = bust_q;
  assign illegal_throw = illegal_q;
  assign game_over     = game_over_q;
  assign winner        = winner_q;

endmodule

// File: tb/tb_dartboard_turn_sequencer.sv
module tb_dartboard_turn_sequencer;

  localparam int START = 501;
  localparam bit DO    = 1'b1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       new_game = 1'b0;
  logic       throw_valid = 1'b0;
  logic       throw_ready;
  logic [4:0] points = '0;
  logic [2:0] multiplier = 3'd1;
  logic       undo = 1'b0;
  logic [8:0] score_p0, score_p1;
  logic       active_player;
  logic [1:0] darts_left;
  logic       bust, illegal_throw, game_over, winner;

  dartboard_turn_sequencer #(.START_SCORE(START), .DOUBLE_OUT(DO)) dut (
    .clk(clk), .reset(reset), .new_game(new_game), .throw_valid(throw_valid),
    .throw_ready(throw_ready), .points(points), .multiplier(multiplier),
    .undo(undo), .score_p0(score_p0), .score_p1(score_p1),
    .active_player(active_player), .darts_left(darts_left), .bust(bust),
    .illegal_throw(illegal_throw), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural game model: scores per player, a list of this turn's dart
  // values, and flags for "turn over, handover pending" and "game finished".
  int m_sc[2];
  int m_act, m_dl, m_tstart, m_win;
  int m_hist[$];
  bit m_ended, m_over, m_bust, m_ill;

  function automatic void model_reset();
    m_sc[0] = START; m_sc[1] = START;
    m_act = 0; m_dl = 3; m_tstart = START; m_win = 0;
    m_hist.delete();
    m_ended = 0; m_over = 0; m_bust = 0; m_ill = 0;
  endfunction

  initial model_reset();

  always @(posedge clk or negedge reset) begin
    int p, m, v, r;
    bit lg;
    if (!reset) begin
      model_reset();
    end else begin
      m_bust = 0; m_ill = 0;
      if (new_game) begin
        model_reset();
      end else if (m_over) begin
        // finished game: nothing changes
      end else if (m_ended) begin
        m_act = 1 - m_act;
        m_dl = 3;
        m_tstart = m_sc[m_act];
        m_hist.delete();
        m_ended = 0;
      end else if (undo) begin
        if (m_hist.size() > 0) begin
          m_sc[m_act] += m_hist.pop_back();
          m_dl++;
        end
      end else if (throw_valid) begin
        p = int'(points); m = int'(multiplier);
        lg = (m >= 1 && m <= 3) && (p <= 20 || (p == 25 && m <= 2));
        v = lg ? p * m : 0;
        m_ill = !lg;
        r = m_sc[m_act] - v;
        if (r < 0 || (DO && r == 1) || (DO && r == 0 && m != 2)) begin
          m_sc[m_act] = m_tstart;
          m_bust = 1;
          m_ended = 1;
        end else if (r == 0) begin
          m_sc[m_act] = 0;
          m_over = 1;
          m_win = m_act;
        end else begin
          m_sc[m_act] = r;
          m_hist.push_back(v);
          m_dl--;
          if (m_dl == 0) m_ended = 1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("score_p0", int'(score_p0), m_sc[0]);
      check("score_p1", int'(score_p1), m_sc[1]);
      check("active_player", int'(active_player), m_act);
      check("darts_left", int'(darts_left), m_dl);
      check("bust", int'(bust), int'(m_bust));
      check("illegal_throw", int'(illegal_throw), int'(m_ill));
      check("game_over", int'(game_over), int'(m_over));
      if (m_over) check("winner", int'(winner), m_win);
      check("throw_ready", int'(throw_ready),
            int'(!m_over && !m_ended && !undo && !new_game));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic dart(input int p, input int m);
    int n = 0;
    while (!throw_ready && n < 10) begin
      step();
      n++;
    end
    check("dart_ready", int'(throw_ready), 1);
    points = 5'(p); multiplier = 3'(m); throw_valid = 1'b1;
    step();
    throw_valid = 1'b0;
  endtask

  task automatic turn(input int p0, input int k0, input int p1, input int k1,
                      input int p2, input int k2);
    dart(p0, k0); dart(p1, k1); dart(p2, k2);
  endtask

  task automatic zeros();
    turn(0, 1, 0, 1, 0, 1);
  endtask

  task automatic pulse_undo();
    undo = 1'b1; step(); undo = 1'b0;
  endtask

  initial begin
    int r;
    #1 reset = 1'b0;
    #3 chk_en = 1'b1;
    step();
    reset = 1'b1;
    step();
    check("rst_score_p0", int'(score_p0), 501);
    check("rst_score_p1", int'(score_p1), 501);
    check("rst_darts", int'(darts_left), 3);
    check("rst_ready", int'(throw_ready), 1);

    // Undo behaviour
    dart(25, 2);
    check("bull_double", int'(score_p0), 451);
    check("bull_darts", int'(darts_left), 2);
    pulse_undo();
    check("undo_score", int'(score_p0), 501);
    check("undo_darts", int'(darts_left), 3);
    pulse_undo();
    check("undo2_score", int'(score_p0), 501);
    check("undo2_darts", int'(darts_left), 3);
    dart(25, 2);
    undo = 1'b1; throw_valid = 1'b1; points = 5'd20; multiplier = 3'd1;
    #1 check("undo_thr_ready", int'(throw_ready), 0);
    @(posedge clk); #1;
    undo = 1'b0; throw_valid = 1'b0;
    check("undo_thr_score", int'(score_p0), 501);
    check("undo_thr_darts", int'(darts_left), 3);

    // Illegal darts
    dart(22, 1);
    check("ill1_pulse", int'(illegal_throw), 1);
    check("ill1_score", int'(score_p0), 501);
    check("ill1_darts", int'(darts_left), 2);
    step();
    check("ill1_pulse_end", int'(illegal_throw), 0);
    dart(25, 3);
    check("ill2_pulse", int'(illegal_throw), 1);
    check("ill2_score", int'(score_p0), 501);
    check("ill2_darts", int'(darts_left), 1);

    new_game = 1'b1; step(); new_game = 1'b0;
    check("ng_score_p0", int'(score_p0), 501);
    check("ng_active", int'(active_player), 0);
    check("ng_darts", int'(darts_left), 3);

    // Normal turn and TURN_END timing
    turn(20, 3, 20, 3, 20, 3);
    check("turn_score", int'(score_p0), 321);
    check("turn_end_ready", int'(throw_ready), 0);
    check("turn_end_active", int'(active_player), 0);
    step();
    check("turn_next_active", int'(active_player), 1);
    check("turn_next_darts", int'(darts_left), 3);
    check("turn_next_ready", int'(throw_ready), 1);

    // Asynchronous reset between clock edges
    #3 reset = 1'b0;
    #1;
    check("arst_score_p0", int'(score_p0), 501);
    check("arst_active", int'(active_player), 0);
    check("arst_darts", int'(darts_left), 3);
    step();
    reset = 1'b1;
    step();

    // Bring P0 down to 40, then bust twice
    turn(20, 3, 20, 3, 20, 3); zeros();
    turn(20, 3, 20, 3, 20, 3); zeros();
    turn(20, 3, 7, 3, 20, 1);
    check("p0_at_40", int'(score_p0), 40);
    zeros();
    dart(20, 1); dart(20, 1);
    check("single_out_bust", int'(bust), 1);
    check("single_out_score", int'(score_p0), 40);
    step();
    check("bust_pulse_end", int'(bust), 0);
    turn(20, 3, 20, 3, 20, 3);
    dart(20, 1); dart(19, 1);
    check("rem1_bust", int'(bust), 1);
    check("rem1_score", int'(score_p0), 40);
    step();
    check("rem1_next_player", int'(active_player), 1);
    turn(20, 3, 20, 3, 20, 3); zeros();
    turn(20, 3, 7, 3, 20, 1);
    check("p1_at_40", int'(score_p1), 40);
    zeros();
    dart(20, 2);
    check("checkout_score", int'(score_p1), 0);
    check("checkout_over", int'(game_over), 1);
    check("checkout_winner", int'(winner), 1);
    check("checkout_ready", int'(throw_ready), 0);
    throw_valid = 1'b1; points = 5'd20; multiplier = 3'd1;
    step(); throw_valid = 1'b0;
    pulse_undo();
    check("over_hold_p0", int'(score_p0), 40);
    new_game = 1'b1; step(); new_game = 1'b0;
    check("ng_over_score_p1", int'(score_p1), 501);
    check("ng_over_game_over", int'(game_over), 0);
    check("ng_over_winner", int'(winner), 0);

    // Randomized play
    for (int i = 0; i < 6000; i++) begin
      r = int'($urandom_range(0, 999));
      reset = (r == 999) ? 1'b0 : 1'b1;
      new_game = (r < 5) || (m_over && r < 100);
      undo = (r >= 100 && r < 170);
      throw_valid = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 9) == 0) begin
        points = 5'($urandom_range(0, 31));
        multiplier = 3'($urandom_range(0, 7));
      end else begin
        points = ($urandom_range(0, 12) == 0) ? 5'd25 : 5'($urandom_range(0, 20));
        multiplier = 3'($urandom_range(1, 3));
      end
      step();
    end
    reset = 1'b1; new_game = 1'b0; undo = 1'b0; throw_valid = 1'b0;
    step(); step();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
